// File: rtl/br_pkg.sv
// Shared definitions for the decode-stage branch unit.
//   br_op_t    : branch opcode encoding carried on d_br_op (7 is reserved and
//                is treated exactly like BR_NONE)
//   BHT_INIT   : reset value of every 2-bit history counter (weak not-taken)
//   is_branch  : true for the six real branch opcodes
//   ctr_next   : 2-bit saturating counter step (up when taken, down otherwise)
package br_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_op_t;

  localparam logic [1:0] BHT_INIT = 2'b01;

  function automatic logic is_branch(input br_op_t op);
    return (op != BR_NONE) && (op != BR_RSVD);
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/br_cond.sv
// Branch condition evaluator (pure combinational).
//   op      : branch opcode
//   rs_data : forwarded rs operand
//   rt_data : forwarded rt operand (only used by BEQ/BNE)
//   judge   : 1 when the branch condition holds; 0 for NONE/reserved
module br_cond
  import br_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  br_op_t           op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             judge
);

  logic rs_zero;
  logic rs_neg;

  assign rs_zero = (rs_data == '0);
  assign rs_neg  = ($signed(rs_data) < $signed({WIDTH{1'b0}}));

  always_comb begin
    judge = 1'b0;
    case (op)
      BR_BEQ:  judge = (rs_data == rt_data);
      BR_BNE:  judge = (rs_data != rt_data);
      BR_BLEZ: judge = rs_neg | rs_zero;
      BR_BGTZ: judge = ~rs_neg & ~rs_zero;
      BR_BLTZ: judge = rs_neg;
      BR_BGEZ: judge = ~rs_neg;
      default: judge = 1'b0;
    endcase
  end

endmodule

// File: rtl/d_branch_unit.sv
// Decode-stage branch resolution unit.
// Resolves the D-stage branch condition, predicts the F-stage instruction from
// a table of 2-bit saturating counters, flags mispredictions and keeps
// saturating statistics counters.
//   clk, reset     : clock, synchronous active-high reset
//   f_pc           : PC in F, indexes the history table
//   f_pred_taken   : combinational prediction for the F instruction
//   d_en, d_clr    : F->D advance / D flush (flush wins)
//   d_pc, d_br_op  : PC and branch opcode of the D instruction
//   rs_data,rt_data: forwarded operands
//   judge          : branch condition (combinational)
//   d_pred_taken   : prediction that travelled with the D instruction
//   mispredict     : D branch resolved against its prediction
//   br_cnt,miss_cnt: saturating counts of resolved / mispredicted branches
module d_branch_unit
  import br_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      f_pc,
  output logic             f_pred_taken,
  input  logic             d_en,
  input  logic             d_clr,
  input  logic [31:0]      d_pc,
  input  logic [2:0]       d_br_op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             judge,
  output logic             d_pred_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] d_idx;
  br_op_t           op;
  logic             real_br;
  logic             commit;
  logic             unused_pc_bits;

  assign f_idx = f_pc[IDX_W+1:2];
  assign d_idx = d_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{f_pc[31:IDX_W+2], f_pc[1:0], d_pc[31:IDX_W+2], d_pc[1:0]};

  assign op = br_op_t'(d_br_op);

  br_cond #(.WIDTH(WIDTH)) u_cond (
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .judge   (judge)
  );

  assign real_br = is_branch(op);
  // A stalled branch stays in D for several cycles; only the advancing cycle
  // commits, so each branch trains the table and the counters once.
  assign commit  = d_en & ~d_clr & real_br;

  // Combinational read of the current table contents: a same-cycle update to
  // this index is only visible after the edge (read-before-write).
  assign f_pred_taken = bht[f_idx][1];
  assign mispredict   = real_br & (judge ^ d_pred_taken);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= BHT_INIT;
      d_pred_taken <= 1'b0;
      br_cnt       <= '0;
      miss_cnt     <= '0;
    end else begin
      if (commit) begin
        bht[d_idx] <= ctr_next(bht[d_idx], judge);
        if (br_cnt != '1) br_cnt <= br_cnt + 1'b1;
        if (mispredict && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
      end
      if (d_clr)     d_pred_taken <= 1'b0;
      else if (d_en) d_pred_taken <= f_pred_taken;
    end
  end

endmodule

// File: tb/tb_d_branch_unit.sv
// Testbench for d_branch_unit: directed steps against a reference model with
// a scoreboard queue; a second instance with 4-bit counters shares all inputs
// to exercise counter saturation.
module tb_d_branch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        d_en;
  logic        d_clr;
  logic [31:0] d_pc;
  logic [2:0]  d_br_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        judge;
  logic        d_pred_taken;
  logic        mispredict;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  logic        s_f_pred_taken;
  logic        s_judge;
  logic        s_d_pred_taken;
  logic        s_mispredict;
  logic [3:0]  s_br_cnt;
  logic [3:0]  s_miss_cnt;

  d_branch_unit u_dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .d_en(d_en), .d_clr(d_clr), .d_pc(d_pc), .d_br_op(d_br_op),
    .rs_data(rs_data), .rt_data(rt_data), .judge(judge),
    .d_pred_taken(d_pred_taken), .mispredict(mispredict),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  d_branch_unit #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(s_f_pred_taken),
    .d_en(d_en), .d_clr(d_clr), .d_pc(d_pc), .d_br_op(d_br_op),
    .rs_data(rs_data), .rt_data(rt_data), .judge(s_judge),
    .d_pred_taken(s_d_pred_taken), .mispredict(s_mispredict),
    .br_cnt(s_br_cnt), .miss_cnt(s_miss_cnt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [1:0]  m_bht [16];
  logic        m_dpred;
  int unsigned m_br;
  int unsigned m_miss;

  // scoreboard: {judge, mispredict, d_pred_taken, f_pred_taken}
  logic [3:0]  exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // last observed combinational outputs of a step
  logic o_judge, o_mis, o_dpred, o_fpred;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic ref_judge(input logic [2:0] op, input logic [31:0] rs,
                                     input logic [31:0] rt);
    logic z;
    z = (rs == 32'd0);
    case (op)
      3'd1:    return rs == rt;
      3'd2:    return rs != rt;
      3'd3:    return rs[31] | z;
      3'd4:    return ~rs[31] & ~z;
      3'd5:    return rs[31];
      3'd6:    return ~rs[31];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] sat4(input int unsigned v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_dpred = 1'b0;
    m_br    = 0;
    m_miss  = 0;
  endtask

  // driver: one clock cycle of stimulus, checks, then model update at the edge
  task automatic step(input logic rst, input logic en, input logic clr,
                      input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] dpc, input logic [31:0] fpc);
    logic       j, pf, mis, isb;
    logic [3:0] e;
    logic [3:0] di;
    @(negedge clk);
    reset = rst; d_en = en; d_clr = clr; d_br_op = op;
    rs_data = rs; rt_data = rt; d_pc = dpc; f_pc = fpc;
    #1;
    j   = ref_judge(op, rs, rt);
    isb = (op >= 3'd1) && (op <= 3'd6);
    pf  = m_bht[fpc[5:2]][1];
    mis = isb & (j != m_dpred);
    exp_q.push_back({j, mis, m_dpred, pf});
    check("br_cnt",     br_cnt,           m_br);
    check("miss_cnt",   miss_cnt,         m_miss);
    check("s_br_cnt",   32'(s_br_cnt),    32'(sat4(m_br)));
    check("s_miss_cnt", 32'(s_miss_cnt),  32'(sat4(m_miss)));
    e = exp_q.pop_front();
    check("judge",        32'(judge),        32'(e[3]));
    check("mispredict",   32'(mispredict),   32'(e[2]));
    check("d_pred_taken", 32'(d_pred_taken), 32'(e[1]));
    check("f_pred_taken", 32'(f_pred_taken), 32'(e[0]));
    o_judge = judge; o_mis = mispredict; o_dpred = d_pred_taken; o_fpred = f_pred_taken;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (en && !clr && isb) begin
        di = dpc[5:2];
        if (j && m_bht[di] != 2'b11) m_bht[di] = m_bht[di] + 2'b01;
        else if (!j && m_bht[di] != 2'b00) m_bht[di] = m_bht[di] - 2'b01;
        if (m_br != 32'hFFFF_FFFF) m_br++;
        if (mis && m_miss != 32'hFFFF_FFFF) m_miss++;
      end
      if (clr)     m_dpred = 1'b0;
      else if (en) m_dpred = pf;
    end
  endtask

  initial begin
    logic [1:0]  sat_exp [8];
    int unsigned br_before;
    sat_exp = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};

    reset = 1'b1; d_en = 1'b0; d_clr = 1'b0; d_br_op = 3'd0;
    rs_data = '0; rt_data = '0; d_pc = '0; f_pc = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // reset state
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_br_cnt",   br_cnt,   32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    check("rst_dpred",    32'(d_pred_taken), 32'd0);
    check("rst_fpred",    32'(f_pred_taken), 32'd0);
    for (int i = 0; i < 16; i++) check("rst_bht", 32'(u_dut.bht[i]), 32'd1);

    // first BEQ, taken, predicted not-taken
    step(0, 1, 0, 3'd1, 32'd5, 32'd5, 32'h3000, 32'h0);
    check("beq_judge", 32'(o_judge), 32'd1);
    check("beq_dpred", 32'(o_dpred), 32'd0);
    check("beq_mis",   32'(o_mis),   32'd1);
    #1;
    check("beq_bht0", 32'(u_dut.bht[0]), 32'd2);
    check("beq_br",   br_cnt,   32'd1);
    check("beq_miss", miss_cnt, 32'd1);

    // signed-condition sweep (no commit, except reserved which never commits)
    step(0, 0, 0, 3'd3, 32'd0, 32'd7, 32'h3080, 32'h0);
    check("blez_0", 32'(o_judge), 32'd1);
    step(0, 0, 0, 3'd4, 32'h8000_0000, 32'd0, 32'h3080, 32'h0);
    check("bgtz_min", 32'(o_judge), 32'd0);
    step(0, 0, 0, 3'd5, 32'hFFFF_FFFF, 32'd0, 32'h3080, 32'h0);
    check("bltz_m1", 32'(o_judge), 32'd1);
    step(0, 0, 0, 3'd6, 32'd0, 32'd0, 32'h3080, 32'h0);
    check("bgez_0", 32'(o_judge), 32'd1);
    step(0, 0, 0, 3'd2, 32'd3, 32'd3, 32'h3080, 32'h0);
    check("bne_eq", 32'(o_judge), 32'd0);
    step(0, 1, 0, 3'd7, 32'd9, 32'd9, 32'h3080, 32'h0);
    check("rsvd_judge", 32'(o_judge), 32'd0);
    check("rsvd_mis",   32'(o_mis),   32'd0);
    #1;
    check("rsvd_br", br_cnt, 32'd1);

    // counter saturation at index 4: four taken then four not-taken
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 3'd1, 32'd1, (i < 4) ? 32'd1 : 32'd2, 32'h3010, 32'h3000);
      #1;
      check("sat_bht4", 32'(u_dut.bht[4]), 32'(sat_exp[i]));
    end

    // stall: branch held in D commits once
    br_before = m_br;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 3'd1, 32'd4, 32'd4, 32'h3040, 32'h3000);
      #1;
      check("stall_br", br_cnt, br_before);
    end
    step(0, 1, 0, 3'd1, 32'd4, 32'd4, 32'h3040, 32'h3000);
    #1;
    check("stall_release", br_cnt, br_before + 1);

    // read-before-write at index 3, then flush beats enable
    step(0, 1, 0, 3'd1, 32'd1, 32'd1, 32'h100C, 32'h200C);
    check("rbw_now", 32'(o_fpred), 32'd0);
    br_before = m_br;
    step(0, 1, 1, 3'd1, 32'd1, 32'd1, 32'h100C, 32'h200C);
    check("rbw_next", 32'(o_fpred), 32'd1);
    #1;
    check("clr_dpred", 32'(d_pred_taken), 32'd0);
    check("clr_no_commit", br_cnt, br_before);

    // random mix
    for (int i = 0; i < 24; i++) begin
      step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
           ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom,
           {$urandom_range(0, 255), 2'b00}, {$urandom_range(0, 255), 2'b00});
    end

    // miss counter saturation on the 4-bit instance
    for (int i = 0; i < 16; i++)
      step(0, 1, 0, 3'd1, 32'd6, 32'd6, 32'h3020, 32'h3024);
    #1;
    check("miss_sat4", 32'(s_miss_cnt), 32'd15);
    check("br_sat4",   32'(s_br_cnt),   32'd15);

    // reset mid-stream discards the commit in that cycle
    step(1, 1, 0, 3'd1, 32'd2, 32'd2, 32'h3010, 32'h3000);
    #1;
    check("mid_rst_br",   br_cnt,   32'd0);
    check("mid_rst_miss", miss_cnt, 32'd0);
    check("mid_rst_bht4", 32'(u_dut.bht[4]), 32'd1);
    step(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
